// File: rtl/forwarding_scoreboard_if.sv
// ID-stage instruction fields, mode controls and forwarding/stall results shared between the
// pipeline control logic (master) and the forwarding scoreboard (slave).
interface forwarding_scoreboard_if #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SEL_W   = 2
);

  logic                      fwd_en;
  logic                      pipe_freeze;
  logic                      flush;
  logic                      id_valid;
  logic [REG_AW-1:0]         id_dest;
  logic                      id_wb_en;
  logic                      id_is_load;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      hazard_stall;
  logic [NUM_SRC*SEL_W-1:0]  exe_sel;
  logic [15:0]               stall_count;

  modport master (
    output fwd_en,
    output pipe_freeze,
    output flush,
    output id_valid,
    output id_dest,
    output id_wb_en,
    output id_is_load,
    output id_src,
    output id_src_used,
    input  hazard_stall,
    input  exe_sel,
    input  stall_count
  );

  modport slave (
    input  fwd_en,
    input  pipe_freeze,
    input  flush,
    input  id_valid,
    input  id_dest,
    input  id_wb_en,
    input  id_is_load,
    input  id_src,
    input  id_src_used,
    output hazard_stall,
    output exe_sel,
    output stall_count
  );

endinterface

// File: rtl/forwarding_scoreboard.sv
// Shadow tag pipeline of in-flight writers (EXE plus FWD_STAGES later stages) that produces
// per-source EXE forwarding selects and the ID-stage hazard stall.
module forwarding_scoreboard #(
  parameter int unsigned REG_AW         = 4,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned FWD_STAGES     = 2,
  parameter int unsigned LOAD_FWD_STAGE = 2,
  parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
  input logic                    clk,
  input logic                    rst_n,
  forwarding_scoreboard_if.slave sb
);

  // Tag entries: index 0 is EXE, index k is the k-th stage after EXE.
  logic [FWD_STAGES:0]             valid_q;
  logic [FWD_STAGES:0]             wb_en_q;
  logic [FWD_STAGES:0]             is_load_q;
  logic [FWD_STAGES:0][REG_AW-1:0] dest_q;
  logic [NUM_SRC-1:0][REG_AW-1:0]  src_q;
  logic [NUM_SRC-1:0]              used_q;
  logic [15:0]                     stall_count_q, stall_count_d;

  logic                              entry0_valid_d;
  logic                              hazard_stall;
  logic [NUM_SRC*SEL_W-1:0]          exe_sel;
  logic [FWD_STAGES:0][NUM_SRC-1:0]  id_hit;
  logic [FWD_STAGES:1][NUM_SRC-1:0]  exe_hit;

  // Source/dest match matrices: ID sources against every entry, EXE sources against later stages.
  always_comb begin
    id_hit  = '0;
    exe_hit = '0;
    for (int k = 0; k <= int'(FWD_STAGES); k++) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (valid_q[k] && wb_en_q[k]) begin
          id_hit[k][i] = sb.id_src_used[i] &&
                         (dest_q[k] == sb.id_src[i*REG_AW +: REG_AW]);
        end
      end
    end
    for (int k = 1; k <= int'(FWD_STAGES); k++) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (valid_q[k] && wb_en_q[k]) begin
          exe_hit[k][i] = used_q[i] && (dest_q[k] == src_q[i]);
        end
      end
    end
  end

  // Forwarding mode only stalls on loads too young to forward next cycle; stall-only mode waits
  // until the writer reaches the last stage, where write-before-read covers it.
  always_comb begin
    hazard_stall = 1'b0;
    for (int k = 0; k <= int'(FWD_STAGES); k++) begin
      if (sb.fwd_en) begin
        if (is_load_q[k] && (k <= int'(LOAD_FWD_STAGE) - 2) && (|id_hit[k])) begin
          hazard_stall = 1'b1;
        end
      end else if ((k < int'(FWD_STAGES)) && (|id_hit[k])) begin
        hazard_stall = 1'b1;
      end
    end
    hazard_stall = hazard_stall & sb.id_valid;
  end

  always_comb begin
    exe_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      // Descending scan so the youngest matching stage is written last and wins.
      for (int k = int'(FWD_STAGES); k >= 1; k--) begin
        if (exe_hit[k][i]) begin
          exe_sel[i*SEL_W +: SEL_W] = (is_load_q[k] && (k < int'(LOAD_FWD_STAGE))) ?
                                      '0 : SEL_W'(k);
        end
      end
    end
    if (!sb.fwd_en || !valid_q[0]) begin
      exe_sel = '0;
    end
  end

  always_comb begin
    entry0_valid_d = sb.id_valid & ~hazard_stall & ~sb.flush;
    stall_count_d  = stall_count_q;
    if (hazard_stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      wb_en_q       <= '0;
      is_load_q     <= '0;
      dest_q        <= '0;
      src_q         <= '0;
      used_q        <= '0;
      stall_count_q <= '0;
    end else if (!sb.pipe_freeze) begin
      for (int k = 1; k <= int'(FWD_STAGES); k++) begin
        valid_q[k]   <= valid_q[k-1];
        wb_en_q[k]   <= wb_en_q[k-1];
        is_load_q[k] <= is_load_q[k-1];
        dest_q[k]    <= dest_q[k-1];
      end
      valid_q[0]   <= entry0_valid_d;
      wb_en_q[0]   <= sb.id_wb_en;
      is_load_q[0] <= sb.id_is_load;
      dest_q[0]    <= sb.id_dest;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        src_q[i] <= sb.id_src[i*REG_AW +: REG_AW];
      end
      used_q        <= sb.id_src_used;
      stall_count_q <= stall_count_d;
    end
  end

  assign sb.hazard_stall = hazard_stall;
  assign sb.exe_sel      = exe_sel;
  assign sb.stall_count  = stall_count_q;

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised successor to the two-source forwarding unit. It keeps an internal shadow tag pipeline of in-flight writers (EXE, then FWD_STAGES forwarding stages). It drives per-source forwarding selects for the EXE stage and the ID-stage hazard stall, in both forwarding and non-forwarding modes. It sits beside the hazard detection logic and feeds the EXE operand muxes and the IF/ID stall/bubble controls.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 2, source operands per instruction
FWD_STAGES, 2, forwarding stages after EXE (stage 1 = MEM, stage 2 = WB, ...)
LOAD_FWD_STAGE, 2, first stage index at which load data is forwardable (1..FWD_STAGES)
SEL_W, clog2(FWD_STAGES+1), width of each select field (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
pipe_freeze  in  1  global hold (memory wait); no tag moves
flush  in  1  kill the ID instruction (taken branch); insert bubble
id_valid  in  1  ID holds a real instruction
id_dest  in  REG_AW  ID destination register
id_wb_en  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is a load
id_src  in  NUM_SRC*REG_AW  ID source registers; field i = bits [i*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  per-source valid bits
hazard_stall  out  1  hold PC and IF/ID, bubble into EXE
exe_sel  out  NUM_SRC*SEL_W  per-EXE-source select; 0 = register file, k = stage k result
stall_count  out  16  saturating count of cycles with hazard_stall=1 and pipe_freeze=0

Behaviour:
- Tag entries 0..FWD_STAGES; entry 0 = EXE. Each entry holds valid, dest, wb_en, is_load. Entry 0 also holds srcs and used bits.
- Reset (rst_n=0, async): all entries invalid, stall_count=0. Hence hazard_stall=0 and exe_sel=0 immediately.
- Advance on each clk edge unless pipe_freeze=1:
  - entry k ← entry k-1 for k≥1.
  - entry 0 ← ID fields if id_valid & !hazard_stall & !flush; otherwise entry 0 ← bubble (valid=0).
  - The oldest entry drops off.
- pipe_freeze=1 overrides stall and flush: all entries hold and stall_count holds.
- "Match(s, k)" = entry k valid & wb_en & dest==s. Only used sources count.
- hazard_stall (combinational from ID inputs and entries):
  - fwd_en=1: asserted if id_valid and any used ID source matches an is_load entry k with k ≤ LOAD_FWD_STAGE-2.
  - fwd_en=0: asserted if id_valid and any used ID source matches any entry k in 0..FWD_STAGES-1. The last stage is excluded because the register file is write-before-read.
  - Asserted regardless of flush; flush and stall together produce a single bubble.
- exe_sel field i (combinational from registered entries):
  - Value is the lowest k in 1..FWD_STAGES with entry0 valid & used[i] & Match(src[i], k); 0 if no match or fwd_en=0.
  - Nearest (youngest) stage wins; multiple matches never select the older stage.
  - A load match at k < LOAD_FWD_STAGE cannot occur in forwarding mode because the stall prevents it. If it does occur (fwd_en toggled mid-flight), select is 0.
- stall_count: increments by 1 when hazard_stall & !pipe_freeze; saturates at 16'hFFFF.
- fwd_en changes take effect combinationally; entries are unaffected.
- Invalid or unused sources never match, even when equal to a dest. Register 0 is not special.

Test Plan:
- Reset mid-stream with entries valid: rst_n=0 -> hazard_stall=0, exe_sel=0, stall_count=0 asynchronously; after release the first ID instruction reaches entry 0 one edge later.
- fwd_en=1, ADD r1 then SUB r2=r1,r3 back-to-back -> SUB in EXE: exe_sel src0=1, src1=0, no stall. With one NOP between -> src0=2.
- Double writer: r1 written at stage 1 and stage 2, EXE reads r1 -> exe_sel=1 (nearest), not 2.
- Load-use: LDR r4 then ADD r5=r4 (fwd_en=1) -> hazard_stall=1 for exactly 1 cycle, bubble in entry 0, then exe_sel=2, stall_count=1.
- fwd_en=0, ADD r1 then use r1 -> hazard_stall=1 for 2 cycles (entries 0,1), exe_sel always 0, stall_count=2.
- pipe_freeze=1 during a stall for 3 cycles -> entries, outputs and stall_count hold. flush with a stall -> one bubble, ID instruction never enters entry 0.
